fetch_decode_ctrl: RTL and testbench

FETCH_DECODE_CTRL -- requirements
Module: fetch_decode_ctrl

---
 rtl/fetch_decode_ctrl.sv | 157 +++++++++++++++
 tb/tb_fetch_decode_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode/execute control FSM for a 16-bit-instruction datapath.
// Optional FDC_INSTR_CNT_EN adds a saturating 16-bit instr_cnt port.
module fetch_decode_ctrl #(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [15:0]        IR,
  output logic               PC_clr,
  output logic               PC_up,
  output logic               IR_ld,
  output logic [DADDR_W-1:0] D_addr,
  output logic               D_wr,
  output logic               RF_s,
  output logic [RADDR_W-1:0] RF_W_addr,
  output logic [RADDR_W-1:0] RF_Ra_addr,
  output logic [RADDR_W-1:0] RF_Rb_addr,
  output logic               RF_W_wr,
  output logic               RF_Ra_rd,
  output logic               RF_Rb_rd,
  output logic [2:0]         ALU_s0,
  output logic               halt,
  output logic [3:0]         state_dbg
`ifdef FDC_INSTR_CNT_EN
  ,
  output logic [15:0]        instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_NOOP, S_LOAD_A,
    S_LOAD_B, S_STORE, S_ADD, S_SUB, S_HALT
  } state_t;

  typedef struct packed {
    logic               pc_clr;
    logic               pc_up;
    logic               ir_ld;
    logic [DADDR_W-1:0] d_addr;
    logic               d_wr;
    logic               rf_s;
    logic [RADDR_W-1:0] w_addr;
    logic [RADDR_W-1:0] ra_addr;
    logic [RADDR_W-1:0] rb_addr;
    logic               w_wr;
    logic               ra_rd;
    logic               rb_rd;
    logic [2:0]         alu;
    logic               halt;
  } ctl_t;

  state_t state, state_nxt;
  ctl_t   ctl;

  function automatic state_t next_of(input state_t s, input logic [15:0] ir);
    state_t n;
    case (s)
      S_INIT:   n = S_FETCH;
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (ir[15:12])
          4'h1:    n = S_STORE;
          4'h2:    n = S_LOAD_A;
          4'h3:    n = S_ADD;
          4'h4:    n = S_SUB;
          4'h5:    n = S_HALT;
          default: n = S_NOOP;
        endcase
      end
      S_LOAD_A: n = S_LOAD_B;
      S_HALT:   n = S_HALT;
      default:  n = S_FETCH;
    endcase
    return n;
  endfunction

  // Control word for a state; IR is the instruction register, stable from DECODE through execute.
  function automatic ctl_t decode(input state_t s, input logic [15:0] ir);
    ctl_t c;
    c = '0;
    case (s)
      S_INIT:  c.pc_clr = 1'b1;
      S_FETCH: begin
        c.ir_ld = 1'b1;
        c.pc_up = 1'b1;
      end
      S_STORE: begin
        c.d_addr  = DADDR_W'(ir[7:0]);
        c.ra_addr = RADDR_W'(ir[11:8]);
        c.ra_rd   = 1'b1;
        c.d_wr    = 1'b1;
      end
      S_LOAD_A: begin
        c.d_addr = DADDR_W'(ir[7:0]);
        c.rf_s   = 1'b1;
      end
      S_LOAD_B: begin
        c.d_addr = DADDR_W'(ir[7:0]);
        c.rf_s   = 1'b1;
        c.w_addr = RADDR_W'(ir[11:8]);
        c.w_wr   = 1'b1;
      end
      S_ADD, S_SUB: begin
        c.ra_addr = RADDR_W'(ir[11:8]);
        c.rb_addr = RADDR_W'(ir[7:4]);
        c.w_addr  = RADDR_W'(ir[3:0]);
        c.ra_rd   = 1'b1;
        c.rb_rd   = 1'b1;
        c.w_wr    = 1'b1;
        c.alu     = (s == S_ADD) ? 3'b001 : 3'b010;
      end
      S_HALT:  c.halt = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  assign state_nxt = next_of(state, IR);

  // Outputs are registered alongside the state so they always match the state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
      ctl   <= decode(S_INIT, 16'h0000);
    end else begin
      state <= state_nxt;
      ctl   <= decode(state_nxt, IR);
    end
  end

  assign PC_clr     = ctl.pc_clr;
  assign PC_up      = ctl.pc_up;
  assign IR_ld      = ctl.ir_ld;
  assign D_addr     = ctl.d_addr;
  assign D_wr       = ctl.d_wr;
  assign RF_s       = ctl.rf_s;
  assign RF_W_addr  = ctl.w_addr;
  assign RF_Ra_addr = ctl.ra_addr;
  assign RF_Rb_addr = ctl.rb_addr;
  assign RF_W_wr    = ctl.w_wr;
  assign RF_Ra_rd   = ctl.ra_rd;
  assign RF_Rb_rd   = ctl.rb_rd;
  assign ALU_s0     = ctl.alu;
  assign halt       = ctl.halt;
  assign state_dbg  = state;

`ifdef FDC_INSTR_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      instr_cnt <= '0;
    else if (state == S_DECODE && instr_cnt != 16'hFFFF)
      instr_cnt <= instr_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: instruction-level model builds expected per-cycle outputs.
module tb_fetch_decode_ctrl;

  localparam logic [3:0] ST_INIT = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_NOOP = 4'd3,
                         ST_LDA = 4'd4, ST_LDB = 4'd5, ST_STORE = 4'd6, ST_ADD = 4'd7,
                         ST_SUB = 4'd8, ST_HALT = 4'd9;

  logic        Clk, Reset;
  logic [15:0] IR;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_wr, RF_Ra_rd, RF_Rb_rd, halt;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state_dbg;
  logic [2:0]  ALU_s0;
`ifdef FDC_INSTR_CNT_EN
  logic [15:0] instr_cnt;
`endif

  fetch_decode_ctrl #(.DADDR_W(8), .RADDR_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .IR(IR),
    .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .RF_W_wr(RF_W_wr), .RF_Ra_rd(RF_Ra_rd), .RF_Rb_rd(RF_Rb_rd),
    .ALU_s0(ALU_s0), .halt(halt), .state_dbg(state_dbg)
`ifdef FDC_INSTR_CNT_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct packed {
    logic [3:0] st;
    logic       pc_clr, pc_up, ir_ld;
    logic [7:0] da;
    logic       dwr, rfs;
    logic [3:0] wa, ra, rb;
    logic       wwr, rrd, brd;
    logic [2:0] alu;
    logic       hlt;
  } obs_t;

  obs_t        q[$];
  logic [15:0] prog [16];
  int          pc;
  int          cyc;
  bit          lit_en;
  int          checks = 0;
  int          failures = 0;

  function automatic obs_t idle(input logic [3:0] st);
    obs_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.st = state_dbg; r.pc_clr = PC_clr; r.pc_up = PC_up; r.ir_ld = IR_ld;
    r.da = D_addr; r.dwr = D_wr; r.rfs = RF_s;
    r.wa = RF_W_addr; r.ra = RF_Ra_addr; r.rb = RF_Rb_addr;
    r.wwr = RF_W_wr; r.rrd = RF_Ra_rd; r.brd = RF_Rb_rd;
    r.alu = ALU_s0; r.hlt = halt;
    return r;
  endfunction

  // Cycle sequence an instruction must produce: FETCH, DECODE, then its execute cycle(s).
  task automatic model_instr(input logic [15:0] ir, input int halt_cycles);
    obs_t r;
    r = idle(ST_FETCH); r.ir_ld = 1'b1; r.pc_up = 1'b1; q.push_back(r);
    q.push_back(idle(ST_DECODE));
    case (ir[15:12])
      4'h1: begin
        r = idle(ST_STORE); r.da = ir[7:0]; r.ra = ir[11:8]; r.rrd = 1'b1; r.dwr = 1'b1;
        q.push_back(r);
      end
      4'h2: begin
        r = idle(ST_LDA); r.da = ir[7:0]; r.rfs = 1'b1; q.push_back(r);
        r.st = ST_LDB; r.wa = ir[11:8]; r.wwr = 1'b1; q.push_back(r);
      end
      4'h3, 4'h4: begin
        r = idle((ir[15:12] == 4'h3) ? ST_ADD : ST_SUB);
        r.ra = ir[11:8]; r.rb = ir[7:4]; r.wa = ir[3:0];
        r.rrd = 1'b1; r.brd = 1'b1; r.wwr = 1'b1;
        r.alu = (ir[15:12] == 4'h3) ? 3'b001 : 3'b010;
        q.push_back(r);
      end
      4'h5: begin
        r = idle(ST_HALT); r.hlt = 1'b1;
        repeat (halt_cycles) q.push_back(r);
      end
      default: q.push_back(idle(ST_NOOP));
    endcase
  endtask

  task automatic push_init();
    obs_t r;
    r = idle(ST_INIT); r.pc_clr = 1'b1;
    q.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Hand-computed expectations for the first program, indexed from its first FETCH.
  task automatic literal_checks();
    case (cyc)
      0:  begin chk("fetch_irld", {31'd0, IR_ld}, 1); chk("fetch_pcup", {31'd0, PC_up}, 1); end
      2:  chk("noop_state", {28'd0, state_dbg}, 3);
      3:  chk("refetch_3cyc", {28'd0, state_dbg}, 1);
      5:  begin chk("lda_daddr", {24'd0, D_addr}, 32'h1B); chk("lda_wwr", {31'd0, RF_W_wr}, 0); end
      6:  begin chk("ldb_waddr", {28'd0, RF_W_addr}, 32'hA); chk("ldb_wwr", {31'd0, RF_W_wr}, 1); end
      7:  chk("load_refetch", {28'd0, state_dbg}, 1);
      9:  begin
        chk("st_daddr", {24'd0, D_addr}, 5); chk("st_ra", {28'd0, RF_Ra_addr}, 3);
        chk("st_dwr", {31'd0, D_wr}, 1);
      end
      10: chk("st_dwr_once", {31'd0, D_wr}, 0);
      12: chk("add_regs", {17'd0, ALU_s0, RF_Ra_addr, RF_Rb_addr, RF_W_addr}, {17'd0, 3'b001, 12'h127});
      15: chk("sub_regs", {17'd0, ALU_s0, RF_Ra_addr, RF_Rb_addr, RF_W_addr}, {17'd0, 3'b010, 12'h127});
      18: chk("f000_noop", {28'd0, state_dbg}, 3);
      40: chk("halt_held", {30'd0, halt, IR_ld}, 32'h2);
      default: ;
    endcase
  endtask

  // One sampled cycle: compare against the model, then act as PC and instruction register.
  task automatic step();
    obs_t e, a;
    @(negedge Clk);
    a = sample();
    e = q.pop_front();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL cycle cyc=%0d got=%h want=%h", cyc, a, e);
    end
    if (lit_en) literal_checks();
    if (IR_ld) IR = prog[pc[3:0]];
    if (PC_clr) pc = 0;
    else if (PC_up) pc = pc + 1;
    cyc++;
  endtask

  task automatic run_q();
    while (q.size() > 0) step();
  endtask

  initial begin
    Reset = 1'b1;
    IR = 16'h0000;
    pc = 0; cyc = 0; lit_en = 1'b0;
    foreach (prog[i]) prog[i] = 16'h0000;
    prog[0] = 16'h0000; prog[1] = 16'h2A1B; prog[2] = 16'h1305; prog[3] = 16'h3127;
    prog[4] = 16'h4127; prog[5] = 16'hF000; prog[6] = 16'h5000;

    // Program A: every opcode, ending in HALT held for 20 cycles.
    repeat (2) @(posedge Clk);
    push_init();
    run_q();
`ifdef FDC_INSTR_CNT_EN
    chk("cnt_reset", {16'd0, instr_cnt}, 0);
`endif
    #2 Reset = 1'b0;
    cyc = 0;
    lit_en = 1'b1;
    for (int i = 0; i < 7; i++) model_instr(prog[i], 20);
    run_q();
    lit_en = 1'b0;
`ifdef FDC_INSTR_CNT_EN
    chk("cnt_after_a", {16'd0, instr_cnt}, 7);
`endif

    // Reset out of HALT, then reset again in the middle of a LOAD.
    #2 Reset = 1'b1;
    #1 chk("halt_reset_async", {28'd0, state_dbg}, 0);
    foreach (prog[i]) prog[i] = 16'h0000;
    prog[0] = 16'h2A1B; prog[1] = 16'hF000; prog[2] = 16'h3127; prog[3] = 16'h5000;
    push_init();
    run_q();
    #2 Reset = 1'b0;
    model_instr(prog[0], 0);
    repeat (3) step();
    q.delete();
    chk("mid_load_state", {28'd0, state_dbg}, 4);
    #2 Reset = 1'b1;
    #1;
    chk("rst_state", {28'd0, state_dbg}, 0);
    chk("rst_pcclr", {31'd0, PC_clr}, 1);
    chk("rst_other", {8'd0, D_addr, RF_s, halt, IR_ld, PC_up, 4'd0, RF_W_wr, D_wr, ALU_s0, 7'd0}, 0);
`ifdef FDC_INSTR_CNT_EN
    chk("rst_cnt", {16'd0, instr_cnt}, 0);
`endif
    push_init();
    run_q();
    #2 Reset = 1'b0;
    for (int i = 0; i < 4; i++) model_instr(prog[i], 5);
    run_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
